// File: rtl/alu_issue.sv
// Requester-side issue controller for the multi-cycle ALU: accepts one decoded op,
// screens it, drives in_alu until out_alu or timeout, then returns a write-back response.
module alu_issue #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int RD_W           = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [5:0]      req_operation,
   input  logic [5:0]      req_op,
   input  logic [4:0]      req_shamt,
   input  logic [31:0]     req_operand1,
   input  logic [31:0]     req_operand2,
   input  logic [RD_W-1:0] req_rd,
   output logic            in_alu,
   output logic [31:0]     operand1,
   output logic [31:0]     operand2,
   output logic [5:0]      operation,
   output logic [5:0]      op,
   output logic [4:0]      shamt,
   input  logic [31:0]     result,
   input  logic            out_alu,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [RD_W-1:0] wb_rd,
   output logic [31:0]     wb_data,
   output logic [1:0]      wb_err,
   output logic            busy
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [5:0] OPC_FIRST = 6'b000001;
   localparam logic [5:0] OPC_LAST  = 6'b001101;
   localparam logic [5:0] OPC_DIV   = 6'b001100;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_DIVZERO = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            in_alu_q, in_alu_d;
   logic [31:0]     operand1_q, operand1_d;
   logic [31:0]     operand2_q, operand2_d;
   logic [5:0]      operation_q, operation_d;
   logic [5:0]      op_q, op_d;
   logic [4:0]      shamt_q, shamt_d;
   logic [RD_W-1:0] rd_q, rd_d;
   logic [31:0]     wb_data_q, wb_data_d;
   logic [1:0]      wb_err_q, wb_err_d;

   logic opc_legal;
   logic div_zero;

   assign opc_legal = (req_operation >= OPC_FIRST) && (req_operation <= OPC_LAST);
   assign div_zero  = (req_operation == OPC_DIV) && (req_operand2 == 32'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         in_alu_q    <= 1'b0;
         operand1_q  <= '0;
         operand2_q  <= '0;
         operation_q <= '0;
         op_q        <= '0;
         shamt_q     <= '0;
         rd_q        <= '0;
         wb_data_q   <= '0;
         wb_err_q    <= ERR_OK;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         in_alu_q    <= in_alu_d;
         operand1_q  <= operand1_d;
         operand2_q  <= operand2_d;
         operation_q <= operation_d;
         op_q        <= op_d;
         shamt_q     <= shamt_d;
         rd_q        <= rd_d;
         wb_data_q   <= wb_data_d;
         wb_err_q    <= wb_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      in_alu_d    = in_alu_q;
      operand1_d  = operand1_q;
      operand2_d  = operand2_q;
      operation_d = operation_q;
      op_d        = op_q;
      shamt_d     = shamt_q;
      rd_d        = rd_q;
      wb_data_d   = wb_data_q;
      wb_err_d    = wb_err_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               rd_d = req_rd;
               if (!opc_legal) begin
                  wb_err_d  = ERR_ILLEGAL;
                  wb_data_d = '0;
                  state_d   = RESP;
               end else if (div_zero) begin
                  wb_err_d  = ERR_DIVZERO;
                  wb_data_d = '0;
                  state_d   = RESP;
               end else begin
                  operand1_d  = req_operand1;
                  operand2_d  = req_operand2;
                  operation_d = req_operation;
                  op_d        = req_op;
                  shamt_d     = req_shamt;
                  in_alu_d    = 1'b1;
                  timer_d     = '0;
                  state_d     = RUN;
               end
            end
         end

         RUN: begin
            // A done pulse in the final allowed cycle still counts as a good result.
            if (out_alu) begin
               wb_data_d = result;
               wb_err_d  = ERR_OK;
               in_alu_d  = 1'b0;
               state_d   = RESP;
            end else if (timer_q == TIMER_LAST) begin
               wb_data_d = '0;
               wb_err_d  = ERR_TIMEOUT;
               in_alu_d  = 1'b0;
               state_d   = RESP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         RESP: begin
            if (wb_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d  = IDLE;
            in_alu_d = 1'b0;
         end
      endcase
   end

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign wb_valid  = (state_q == RESP);
   assign in_alu    = in_alu_q;
   assign operand1  = operand1_q;
   assign operand2  = operand2_q;
   assign operation = operation_q;
   assign op        = op_q;
   assign shamt     = shamt_q;
   assign wb_rd     = rd_q;
   assign wb_data   = wb_data_q;
   assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized bench for alu_issue: each request's outcome (run length, response latency,
// error code, data) is predicted from the opcode/operand rules and the chosen ALU delay.
module tb_alu_issue;

   localparam int T  = 8;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [5:0]    req_operation = '0;
   logic [5:0]    req_op = '0;
   logic [4:0]    req_shamt = '0;
   logic [31:0]   req_operand1 = '0;
   logic [31:0]   req_operand2 = '0;
   logic [RW-1:0] req_rd = '0;
   logic          in_alu;
   logic [31:0]   operand1, operand2;
   logic [5:0]    operation, op;
   logic [4:0]    shamt;
   logic [31:0]   result = '0;
   logic          out_alu = 1'b0;
   logic          wb_valid;
   logic          wb_ready = 1'b0;
   logic [RW-1:0] wb_rd;
   logic [31:0]   wb_data;
   logic [1:0]    wb_err;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   alu_issue #(.TIMEOUT_CYCLES(T), .RD_W(RW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_operation(req_operation), .req_op(req_op), .req_shamt(req_shamt),
      .req_operand1(req_operand1), .req_operand2(req_operand2), .req_rd(req_rd),
      .in_alu(in_alu), .operand1(operand1), .operand2(operand2),
      .operation(operation), .op(op), .shamt(shamt),
      .result(result), .out_alu(out_alu),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_err(wb_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_alu"},   in_alu, 0);
      check({tag, "_wb_valid"}, wb_valid, 0);
      check({tag, "_busy"},     busy, 0);
      check({tag, "_req_ready"}, req_ready, 1);
      check({tag, "_wb_err"},   wb_err, 0);
      check({tag, "_wb_data"},  wb_data, 0);
      check({tag, "_wb_rd"},    wb_rd, 0);
      check({tag, "_alu_regs"}, {operand1, operand2, operation, op, shamt}, 0);
   endtask

   // Called at a negedge with the DUT idle. d = index of the RUN cycle in which the ALU
   // pulses out_alu (d >= T means it never does); bp = cycles of write-back backpressure.
   task automatic run_op(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [5:0] opx, input logic [RW-1:0] rd,
                         input int d, input logic [31:0] res, input int bp);
      bit legal, dz, issue, seen;
      int exp_run, exp_lat, runs, k;
      logic [1:0]  exp_err;
      logic [31:0] exp_data;
      logic [31:0] hold_data;
      logic [1:0]  hold_err;
      logic [RW-1:0] hold_rd;

      legal    = (opc >= 6'd1) && (opc <= 6'd13);
      dz       = (opc == 6'd12) && (b == 32'd0);
      issue    = legal && !dz;
      exp_run  = !issue ? 0 : (d < T ? d + 1 : T);
      exp_lat  = exp_run + 1;
      exp_err  = !legal ? 2'd1 : dz ? 2'd2 : (d < T ? 2'd0 : 2'd3);
      exp_data = (issue && d < T) ? res : 32'd0;

      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_operation = opc; req_operand1 = a; req_operand2 = b;
      req_shamt = sh; req_op = opx; req_rd = rd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_operation = 6'($urandom); req_operand1 = $urandom; req_operand2 = $urandom;
      req_shamt = 5'($urandom); req_op = 6'($urandom); req_rd = RW'($urandom);

      runs = 0; k = 1; seen = 0;
      while (k <= T + 4) begin
         if (wb_valid) begin
            seen = 1;
            break;
         end
         check("busy_run", busy, 1);
         if (in_alu) begin
            check("alu_inputs", {operand1, operand2, operation, op, shamt}, {a, b, opc, opx, sh});
            out_alu = (runs == d);
            result  = (runs == d) ? res : $urandom;
            runs++;
         end else begin
            out_alu = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      out_alu = 1'b0;
      check("wb_seen", seen, 1);
      check("in_alu_cycles", runs, exp_run);
      check("wb_latency", k, exp_lat);
      check("in_alu_low_resp", in_alu, 0);
      check("wb_err", wb_err, exp_err);
      check("wb_data", wb_data, exp_data);
      check("wb_rd", wb_rd, rd);

      hold_data = wb_data; hold_err = wb_err; hold_rd = wb_rd;
      for (int i = 0; i < bp; i++) begin
         wb_ready = 1'b0;
         req_valid = 1'b1;
         req_operation = 6'd13; req_operand2 = 32'd1;
         out_alu = 1'($urandom); result = $urandom;
         @(negedge clk);
         check("bp_stable", {wb_valid, wb_err, wb_rd, wb_data}, {1'b1, hold_err, hold_rd, hold_data});
         check("bp_req_ready", req_ready, 0);
         check("bp_in_alu", in_alu, 0);
      end
      out_alu = 1'b0;
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      req_valid = 1'b0;
      check("wb_valid_drop", wb_valid, 0);
      check("req_ready_back", req_ready, 1);
      check("in_alu_idle", in_alu, 0);
   endtask

   initial begin
      logic [5:0] opc;
      logic [31:0] b;
      int d;

      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // ADD single-cycle, DIV slow, DIV by zero, illegal opcodes, timeout and boundary
      run_op(6'b001101, 32'd5,  32'd7, 5'd0, 6'd0, 5'd3, 0,  32'd12, 0);
      run_op(6'b001100, 32'd20, 32'd3, 5'd0, 6'd1, 5'd4, 4,  32'd6,  0);
      run_op(6'b001100, 32'd20, 32'd0, 5'd0, 6'd1, 5'd5, 0,  32'd9,  0);
      run_op(6'b111111, 32'd1,  32'd2, 5'd0, 6'd2, 5'd6, 0,  32'd9,  0);
      run_op(6'b000000, 32'd1,  32'd2, 5'd0, 6'd2, 5'd7, 0,  32'd9,  1);
      run_op(6'b001110, 32'd1,  32'd2, 5'd0, 6'd2, 5'd8, 0,  32'd9,  0);
      run_op(6'b000001, 32'd1,  32'd2, 5'd4, 6'd3, 5'd9, 99, 32'd9,  0);
      run_op(6'b000010, 32'd1,  32'd2, 5'd4, 6'd3, 5'd10, T-1, 32'hCAFE, 0);
      run_op(6'b000011, 32'hFFFF_FFFF, 32'd0, 5'd31, 6'd63, 5'd31, 2, 32'hBEEF, 5);

      // Reset during RUN cycle 3 drops the operation with no response
      req_valid = 1'b1; req_operation = 6'd5; req_operand1 = 32'd11; req_operand2 = 32'd22;
      req_rd = 5'd12;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("rst_in_alu_before", in_alu, 1);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      #1 check_reset_outputs("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("no_resp_after_reset", {wb_valid, in_alu, busy}, 3'b000);
      end
      run_op(6'd7, 32'd3, 32'd4, 5'd1, 6'd9, 5'd13, 1, 32'h1234_5678, 0);

      for (int n = 0; n < 40; n++) begin
         opc = ($urandom_range(0, 9) < 7) ? 6'($urandom_range(1, 13)) : 6'($urandom);
         b   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
         d   = $urandom_range(0, T + 2);
         run_op(opc, $urandom, b, 5'($urandom), 6'($urandom), RW'($urandom), d, $urandom,
                $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
